tl_ul_responder: RTL
====================

TL_UL_RESPONDER -- requirements
Module: tl_ul_responder

Interface
REQ-001 Parameter SOURCE_W, default 4, is the width of the TL a_source and d_source fields.
REQ-002 Parameter ADDR_W, default 12, is the width of the register-side address; it decodes byte addresses 0 to 2^ADDR_W-1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low; asserted when 0.
REQ-005 tlr_i_a_opcode  input  3  Get=4, PutFullData=0, PutPartialData=1.
REQ-006 tlr_i_a_param  input  3  ignored.
REQ-007 tlr_i_a_size  input  2  log2 of the byte count.
REQ-008 tlr_i_a_source  input  SOURCE_W  requester ID.
REQ-009 tlr_i_a_address  input  32  byte address.
REQ-010 tlr_i_a_mask  input  4  byte lanes.
REQ-011 tlr_i_a_data  input  32  write data.
REQ-012 tlr_i_a_corrupt  input  1  write data corrupt.
REQ-013 tlr_i_a_valid  input  1  / tlr_o_a_ready  output  1  A-channel handshake.
REQ-014 tlr_o_d_opcode  output  3  AccessAck=0, AccessAckData=1.
REQ-015 tlr_o_d_param  output  3  always 0.
REQ-016 tlr_o_d_size  output  2  echo of the accepted a_size.
REQ-017 tlr_o_d_source  output  SOURCE_W  echo of the accepted a_source.
REQ-018 tlr_o_d_sink  output  1  always 0.
REQ-019 tlr_o_d_denied  output  1  error flag.
REQ-020 tlr_o_d_data  output  32  read data.
REQ-021 tlr_o_d_corrupt  output  1  read data corrupt.
REQ-022 tlr_o_d_valid  output  1  / tlr_i_d_ready  input  1  D-channel handshake.
REQ-023 tlr_o_reg_req  output  1  register access request, held until accepted.
REQ-024 tlr_o_reg_we  output  1  1 = write.
REQ-025 tlr_o_reg_addr  output  ADDR_W  byte address.
REQ-026 tlr_o_reg_wmask  output  4  byte write enables.
REQ-027 tlr_o_reg_wdata  output  32  write data.
REQ-028 tlr_i_reg_rdata  input  32  read data, sampled only in the cycle where reg_req and reg_ready are both high.
REQ-029 tlr_i_reg_ready  input  1  access completes in any cycle where reg_req is also high.

Function
REQ-030 The FSM SHALL have three states, IDLE, ACCESS and RESP, with at most one transaction outstanding.
REQ-031 a_ready SHALL be 1 only in IDLE; an A fire (valid & ready) SHALL capture opcode, size, source, address, mask, data and corrupt into registers.
REQ-032 Lane mask L SHALL be derived from size and address: size 0 -> 1<<addr[1:0]; size 1 -> 4'b0011<<(2*addr[1]); size 2 -> 4'hF.
REQ-033 A request SHALL be an error if any of these hold: size=3; opcode not in {0,1,4}; address not aligned to its size; address[31:ADDR_W]!=0; PutFull with mask!=L; PutPartial with mask&~L!=0; a Put with corrupt=1.
REQ-034 IDLE SHALL go to ACCESS on a valid fire, or directly to RESP on an error fire.
REQ-035 In ACCESS, reg_req SHALL be 1; reg_we=1 for Puts; wmask=captured mask for Puts and 0 for Get; addr=address[ADDR_W-1:0]; reg_wdata=captured data.
REQ-036 ACCESS SHALL go to RESP in the cycle where reg_ready=1, and Get SHALL capture reg_rdata in that same cycle.
REQ-037 In RESP, d_valid SHALL be 1; d_opcode=1 for Get, 0 for Puts; d_size and d_source SHALL echo the captured values.
REQ-038 In RESP on an error, d_denied SHALL be 1, d_data SHALL be 0, and d_corrupt SHALL be 1 for Get and 0 for Puts; on success, denied=0 and corrupt=0.
REQ-039 RESP SHALL hold all D fields stable until d_ready=1, then go to IDLE.
REQ-040 No combinational path SHALL exist from A inputs to D outputs or reg outputs; minimum latency is A fire at cycle N -> reg_req at N+1 -> d_valid at N+2 with reg_ready=1 (error: d_valid at N+1).
REQ-041 Back-to-back operation: the next A fire SHALL occur no earlier than the cycle after the D fire.
REQ-042 d_data SHALL be 0 for AccessAck responses.

Reset
REQ-043 While rst=0, state SHALL be IDLE and the outputs a_ready, d_valid, reg_req, reg_we, wmask, d_denied and d_corrupt SHALL be 0, with all captured registers 0.
REQ-044 Reset asserted mid-ACCESS or mid-RESP SHALL drop reg_req and d_valid immediately (asynchronously); the transaction is lost.
REQ-045 a_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-046 Get addr 0x008, size 2, source 3, with reg_ready tied 1 and rdata 0xDEADBEEF -> reg_req at N+1 with we=0; d_valid at N+2 with opcode 1, data 0xDEADBEEF, source 3, denied 0.
REQ-047 PutPartial addr 0x006, size 1, mask 4'b1100, data 0xAABB0000 -> reg_we=1, wmask 4'b1100; response AccessAck, denied 0, data 0.
REQ-048 Get addr 0x002 size 2 (misaligned), and separately Get addr 0x1000 with ADDR_W=12 -> no reg_req; d_valid at N+1, denied 1, corrupt 1.
REQ-049 reg_ready held 0 for 5 cycles and d_ready held 0 for 3 cycles -> reg_req held 5 cycles; D fields stable for 3 cycles; a_ready 0 throughout.
REQ-050 rst pulled to 0 during RESP -> d_valid 0 immediately; after release a_ready=1 and a new Get completes normally.

Source files
------------

// File: rtl/tl_ul_responder_if.sv
// TL-UL A/D channel plus the simple register-side request/response bundle.
// The slave modport is the responder's view; the master modport is the requester/register side.
interface tl_ul_responder_if #(
  parameter int SOURCE_W = 4,
  parameter int ADDR_W   = 12
);
  logic [2:0]          tlr_i_a_opcode;
  logic [2:0]          tlr_i_a_param;
  logic [1:0]          tlr_i_a_size;
  logic [SOURCE_W-1:0] tlr_i_a_source;
  logic [31:0]         tlr_i_a_address;
  logic [3:0]          tlr_i_a_mask;
  logic [31:0]         tlr_i_a_data;
  logic                tlr_i_a_corrupt;
  logic                tlr_i_a_valid;
  logic                tlr_o_a_ready;

  logic [2:0]          tlr_o_d_opcode;
  logic [2:0]          tlr_o_d_param;
  logic [1:0]          tlr_o_d_size;
  logic [SOURCE_W-1:0] tlr_o_d_source;
  logic                tlr_o_d_sink;
  logic                tlr_o_d_denied;
  logic [31:0]         tlr_o_d_data;
  logic                tlr_o_d_corrupt;
  logic                tlr_o_d_valid;
  logic                tlr_i_d_ready;

  logic                tlr_o_reg_req;
  logic                tlr_o_reg_we;
  logic [ADDR_W-1:0]   tlr_o_reg_addr;
  logic [3:0]          tlr_o_reg_wmask;
  logic [31:0]         tlr_o_reg_wdata;
  logic [31:0]         tlr_i_reg_rdata;
  logic                tlr_i_reg_ready;

  modport slave (
    input  tlr_i_a_opcode, tlr_i_a_param, tlr_i_a_size, tlr_i_a_source,
           tlr_i_a_address, tlr_i_a_mask, tlr_i_a_data, tlr_i_a_corrupt,
           tlr_i_a_valid, tlr_i_d_ready, tlr_i_reg_rdata, tlr_i_reg_ready,
    output tlr_o_a_ready, tlr_o_d_opcode, tlr_o_d_param, tlr_o_d_size,
           tlr_o_d_source, tlr_o_d_sink, tlr_o_d_denied, tlr_o_d_data,
           tlr_o_d_corrupt, tlr_o_d_valid, tlr_o_reg_req, tlr_o_reg_we,
           tlr_o_reg_addr, tlr_o_reg_wmask, tlr_o_reg_wdata
  );

  modport master (
    output tlr_i_a_opcode, tlr_i_a_param, tlr_i_a_size, tlr_i_a_source,
           tlr_i_a_address, tlr_i_a_mask, tlr_i_a_data, tlr_i_a_corrupt,
           tlr_i_a_valid, tlr_i_d_ready, tlr_i_reg_rdata, tlr_i_reg_ready,
    input  tlr_o_a_ready, tlr_o_d_opcode, tlr_o_d_param, tlr_o_d_size,
           tlr_o_d_source, tlr_o_d_sink, tlr_o_d_denied, tlr_o_d_data,
           tlr_o_d_corrupt, tlr_o_d_valid, tlr_o_reg_req, tlr_o_reg_we,
           tlr_o_reg_addr, tlr_o_reg_wmask, tlr_o_reg_wdata
  );
endinterface

// File: rtl/tl_ul_responder.sv
// Single-outstanding TL-UL responder bridging A/D channels onto a simple register port.
//   state    | meaning
//   S_IDLE   | a_ready high, waiting for an A request
//   S_ACCESS | reg_req held until reg_ready completes the access
//   S_RESP   | d_valid held with stable fields until d_ready
module tl_ul_responder #(
  parameter int SOURCE_W = 4,
  parameter int ADDR_W   = 12
) (
  input logic              clk,
  input logic              rst,
  tl_ul_responder_if.slave bus
);
  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  state_e              state_q;
  logic                a_ready_q;
  logic                reg_req_q;
  logic                reg_we_q;
  logic [3:0]          reg_wmask_q;
  logic                d_valid_q;
  logic                d_denied_q;
  logic                d_corrupt_q;
  logic [31:0]         d_data_q;
  logic [2:0]          opcode_q;
  logic [1:0]          size_q;
  logic [SOURCE_W-1:0] source_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         data_q;

  logic [3:0] lane_mask;
  logic       is_get, is_put_full, is_put_part, is_put;
  logic       misaligned, out_of_range, a_err, a_fire;
  logic       unused_param;

  assign unused_param = ^bus.tlr_i_a_param;

  always_comb begin
    lane_mask = 4'hF;
    case (bus.tlr_i_a_size)
      2'd0:    lane_mask = 4'b0001 << bus.tlr_i_a_address[1:0];
      2'd1:    lane_mask = bus.tlr_i_a_address[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'hF;
    endcase
  end

  assign is_get       = (bus.tlr_i_a_opcode == OP_GET);
  assign is_put_full  = (bus.tlr_i_a_opcode == OP_PUT_FULL);
  assign is_put_part  = (bus.tlr_i_a_opcode == OP_PUT_PART);
  assign is_put       = is_put_full | is_put_part;
  assign misaligned   = ((bus.tlr_i_a_size == 2'd1) & bus.tlr_i_a_address[0]) |
                        ((bus.tlr_i_a_size == 2'd2) & (|bus.tlr_i_a_address[1:0]));
  assign out_of_range = |bus.tlr_i_a_address[31:ADDR_W];
  assign a_err        = (bus.tlr_i_a_size == 2'd3) | ~(is_get | is_put) | misaligned |
                        out_of_range |
                        (is_put_full & (bus.tlr_i_a_mask != lane_mask)) |
                        (is_put_part & (|(bus.tlr_i_a_mask & ~lane_mask))) |
                        (is_put & bus.tlr_i_a_corrupt);
  assign a_fire       = bus.tlr_i_a_valid & a_ready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      a_ready_q   <= 1'b0;
      reg_req_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_wmask_q <= 4'h0;
      d_valid_q   <= 1'b0;
      d_denied_q  <= 1'b0;
      d_corrupt_q <= 1'b0;
      d_data_q    <= 32'h0;
      opcode_q    <= 3'd0;
      size_q      <= 2'd0;
      source_q    <= '0;
      addr_q      <= '0;
      data_q      <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          a_ready_q <= 1'b1;
          if (a_fire) begin
            a_ready_q <= 1'b0;
            opcode_q  <= bus.tlr_i_a_opcode;
            size_q    <= bus.tlr_i_a_size;
            source_q  <= bus.tlr_i_a_source;
            addr_q    <= bus.tlr_i_a_address[ADDR_W-1:0];
            data_q    <= bus.tlr_i_a_data;
            // Errors skip the register port and answer on the next cycle.
            if (a_err) begin
              state_q     <= S_RESP;
              d_valid_q   <= 1'b1;
              d_denied_q  <= 1'b1;
              d_corrupt_q <= is_get;
              d_data_q    <= 32'h0;
            end else begin
              state_q     <= S_ACCESS;
              reg_req_q   <= 1'b1;
              reg_we_q    <= is_put;
              reg_wmask_q <= is_put ? bus.tlr_i_a_mask : 4'h0;
            end
          end
        end
        S_ACCESS: begin
          if (bus.tlr_i_reg_ready) begin
            state_q     <= S_RESP;
            reg_req_q   <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_wmask_q <= 4'h0;
            d_valid_q   <= 1'b1;
            d_denied_q  <= 1'b0;
            d_corrupt_q <= 1'b0;
            d_data_q    <= (opcode_q == OP_GET) ? bus.tlr_i_reg_rdata : 32'h0;
          end
        end
        S_RESP: begin
          if (bus.tlr_i_d_ready) begin
            state_q     <= S_IDLE;
            a_ready_q   <= 1'b1;
            d_valid_q   <= 1'b0;
            d_denied_q  <= 1'b0;
            d_corrupt_q <= 1'b0;
            d_data_q    <= 32'h0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.tlr_o_a_ready   = a_ready_q;
  assign bus.tlr_o_d_opcode  = (opcode_q == OP_GET) ? 3'd1 : 3'd0;
  assign bus.tlr_o_d_param   = 3'd0;
  assign bus.tlr_o_d_size    = size_q;
  assign bus.tlr_o_d_source  = source_q;
  assign bus.tlr_o_d_sink    = 1'b0;
  assign bus.tlr_o_d_denied  = d_denied_q;
  assign bus.tlr_o_d_data    = d_data_q;
  assign bus.tlr_o_d_corrupt = d_corrupt_q;
  assign bus.tlr_o_d_valid   = d_valid_q;
  assign bus.tlr_o_reg_req   = reg_req_q;
  assign bus.tlr_o_reg_we    = reg_we_q;
  assign bus.tlr_o_reg_addr  = addr_q;
  assign bus.tlr_o_reg_wmask = reg_wmask_q;
  assign bus.tlr_o_reg_wdata = data_q;
endmodule
